// File: rtl/opt_io_master.sv
// Host-side sequencer for the option pricing core: loads parameter words,
// holds the core in RUN, waits out the read latency and captures the fp16 price.
`timescale 1ns/1ps
module opt_io_master #(
   parameter int NUM_WORDS  = 4,
   parameter int RUN_CYCLES = 1024,
   parameter int READ_LAT   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [12*NUM_WORDS-1:0] param_wdata,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            price,
   output logic [1:0]             state_o,
   output logic [11:0]            in_o,
   input  logic [15:0]            out_i
);

   localparam int PW = 12 * NUM_WORDS;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;
   localparam logic [1:0] ST_READ = 2'b11;

   localparam logic [15:0] LOAD_LAST = 16'(NUM_WORDS - 1);
   localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);
   localparam logic [15:0] READ_LAST = 16'(READ_LAT - 1);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic [15:0]   cnt_r;
   logic [15:0]   cnt_nxt_s;
   logic [PW-1:0] param_r;
   logic [PW-1:0] param_nxt_s;
   logic [PW-1:0] shifted_s;
   logic [11:0]   in_r;
   logic [11:0]   in_nxt_s;
   logic          capture_s;
   logic          busy_r;
   logic          done_r;
   logic [15:0]   price_r;

   // The latched parameters shift down one word per LOAD cycle, so the next
   // word to present is always the low word of the shifted copy.
   assign shifted_s = param_r >> 4'd12;

   // Next-state, counter and next LOAD word; abort wins over every transition.
   always_comb begin
      state_nxt_s = state_r;
      param_nxt_s = param_r;
      in_nxt_s    = 12'd0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt_s = ST_LOAD;
               param_nxt_s = param_wdata;
               in_nxt_s    = param_wdata[11:0];
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == LOAD_LAST) begin
               state_nxt_s = ST_RUN;
            end else begin
               param_nxt_s = shifted_s;
               in_nxt_s    = shifted_s[11:0];
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == RUN_LAST) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_READ: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == READ_LAST) begin
               state_nxt_s = ST_IDLE;
               capture_s   = 1'b1;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
         cnt_nxt_s = 16'd0;
      end else begin
         cnt_nxt_s = cnt_r + 16'd1;
      end
   end

   // State, phase counter and all outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         param_r <= '0;
         in_r    <= 12'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         price_r <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         param_r <= param_nxt_s;
         in_r    <= in_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= capture_s;
         price_r <= capture_s ? out_i : price_r;
      end
   end

   assign state_o = state_r;
   assign in_o    = in_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign price   = price_r;

endmodule

// File: doc/opt_io_master.md
OPT_IO_MASTER -- requirements
Module: opt_io_master

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NUM_WORDS, 4, number of 12-bit parameter words sent per job.
REQ-002 SHALL provide RUN_CYCLES, 1024, cycles the pricing core is held in RUN (legal 1..65535).
REQ-003 SHALL provide READ_LAT, 2, cycles held in READ before sampling the result (legal 1..255).
Ports (name, direction, width, meaning):
REQ-004 SHALL have clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have start, input, 1, job request pulse from the host.
REQ-007 SHALL have abort, input, 1, cancels the current job.
REQ-008 SHALL have param_wdata, input, 12*NUM_WORDS, option parameters; word i is bits [12i+11:12i].
REQ-009 SHALL have busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 SHALL have done, output, 1, one-cycle pulse when price is valid.
REQ-011 SHALL have price, output, 16, last captured fp16 result.
REQ-012 SHALL have state_o, output, 2, phase code driven to the pricing core.
REQ-013 SHALL have in_o, output, 12, data word driven to the pricing core.
REQ-014 SHALL have out_i, input, 16, result bus from the pricing core.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, READ, with state_o codes 00, 01, 10, 11 respectively.
REQ-016 SHALL drive state_o registered, equal to the current FSM state code.
REQ-017 SHALL drive in_o to 0 in every state except LOAD.
REQ-018 SHALL, in IDLE with start=1 and abort=0, latch param_wdata into an internal register and enter LOAD on the next edge.
REQ-019 SHALL ignore start while busy=1; a start in the same cycle as abort SHALL be ignored.
REQ-020 SHALL, in LOAD cycle c (c = 0..NUM_WORDS-1), drive in_o = latched word c (word 0 first); after exactly NUM_WORDS LOAD cycles it SHALL enter RUN.
REQ-021 SHALL remain in RUN for exactly RUN_CYCLES cycles, then enter READ.
REQ-022 SHALL remain in READ for exactly READ_LAT cycles; on the edge that ends the last READ cycle it SHALL capture out_i into price and return to IDLE.
REQ-023 SHALL assert done for exactly the one cycle following that capture edge, i.e. the first IDLE cycle.
REQ-024 SHALL place start at edge k such that done is high in cycle k+1+NUM_WORDS+RUN_CYCLES+READ_LAT, counting the cycle after edge k as cycle k+1.
REQ-025 SHALL use one shared phase counter of at least 16 bits, cleared on every state change; the counter SHALL never wrap within a legal job.
REQ-026 SHALL, on abort=1 in any non-IDLE state, return to IDLE on the next edge with state_o=00 and in_o=0; done SHALL not pulse and price SHALL be unchanged.
REQ-027 SHALL give abort priority over the READ capture when both occur on the same edge; no capture happens.
REQ-028 SHALL accept a new start in the same cycle that done is high, which is an IDLE cycle.
REQ-029 SHALL hold price stable between captures.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, enter IDLE and set state_o=00, in_o=0, busy=0, done=0, price=0, counter=0, and clear the latched parameters.
REQ-031 SHALL give rst priority over start and abort; reset mid-job discards the job with no done pulse.

Verification (bench uses NUM_WORDS=4, RUN_CYCLES=8, READ_LAT=2)
REQ-032 SHALL cover the basic job: param_wdata=0x004_003_002_001 with a start pulse. The bench checks in_o=001,002,003,004 with state_o=01 over 4 cycles, then state_o=10 for 8 cycles, then 11 for 2 cycles. It then checks price equals the out_i value held at the capture edge, e.g. 0x3C00, and that done pulses once, 15 cycles after start.
REQ-033 SHALL cover busy start: a second start pulse during RUN with different data. Required response: it is ignored, the sequence is unchanged, and exactly one done occurs.
REQ-034 SHALL cover abort mid-RUN: abort in RUN cycle 3. Required response: next cycle state_o=00, busy=0, no done, and price retains its previous value.
REQ-035 SHALL cover abort coinciding with the capture edge: price is unchanged and no done occurs.
REQ-036 SHALL cover reset mid-LOAD: rst=1 during LOAD word 2. Required response: all outputs return to their reset values, and a following start replays from word 0.
REQ-037 SHALL cover back-to-back jobs: start asserted in the done cycle. Required response: LOAD begins next cycle with the new words, and the second done arrives 15 cycles after the second start.
